// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the game flow controller: state encoding, field widths,
// parameter defaults and small saturating helpers.
package game_flow_controller_pkg;

    localparam int STATE_W = 3;
    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 4;
    localparam int PAUSE_W = 8;

    localparam int LIVES_INIT_DEFAULT    = 3;
    localparam int LOST_PAUSE_DEFAULT    = 60;
    localparam int CLEAR_PAUSE_DEFAULT   = 120;
    localparam int UPDATE_CYCLES_DEFAULT = 3;
    localparam int OVERRUN_W_DEFAULT     = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_ATTRACT = 3'd0,
        ST_PLAY    = 3'd1,
        ST_LOST    = 3'd2,
        ST_CLEARED = 3'd3,
        ST_OVER    = 3'd4
    } gameState_t;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    function automatic logic [LEVEL_W-1:0] levelSatInc(input logic [LEVEL_W-1:0] lvl);
        logic [LEVEL_W-1:0] res;
        if (lvl == LEVEL_MAX) begin
            res = lvl;
        end else begin
            res = lvl + 4'd1;
        end
        return res;
    endfunction

    // A loss on the last life empties the counter instead of wrapping.
    function automatic logic [LIVES_W-1:0] livesAfterLoss(input logic [LIVES_W-1:0] lives);
        logic [LIVES_W-1:0] res;
        if (lives <= 3'd1) begin
            res = 3'd0;
        end else begin
            res = lives - 3'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Bundle of the game flow controller's frame/button/event inputs and its
// status outputs; the controller takes the slave side.
interface game_flow_controller_if #(
    parameter int OVERRUN_W = 8
);
    import game_flow_controller_pkg::*;

    logic                 FRAME_START;
    logic                 BTN_START;
    logic                 BALL_LOST;
    logic                 BRICKS_CLEARED;
    logic                 START_UPDATE;
    logic                 BALL_RESET;
    logic [STATE_W-1:0]   GAME_STATE;
    logic [LIVES_W-1:0]   LIVES;
    logic [LEVEL_W-1:0]   LEVEL;
    logic [OVERRUN_W-1:0] OVERRUN_COUNT;

    modport master (
        output FRAME_START, BTN_START, BALL_LOST, BRICKS_CLEARED,
        input  START_UPDATE, BALL_RESET, GAME_STATE, LIVES, LEVEL, OVERRUN_COUNT
    );

    modport slave (
        input  FRAME_START, BTN_START, BALL_LOST, BRICKS_CLEARED,
        output START_UPDATE, BALL_RESET, GAME_STATE, LIVES, LEVEL, OVERRUN_COUNT
    );

endinterface

// File: rtl/game_flow_controller_update_scheduler.sv
// Turns frame strobes into single-cycle update starts, holding off new starts
// while an update is still running and counting the strobes it had to drop.
module update_scheduler #(
    parameter int UPDATE_CYCLES = 3,
    parameter int OVERRUN_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic                 frameStart,
    output logic                 startUpdate,
    output logic [OVERRUN_W-1:0] overrunCount
);

    localparam int BUSY_W = $clog2(UPDATE_CYCLES + 2);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(UPDATE_CYCLES + 1);

    logic [BUSY_W-1:0]    busy_r;
    logic                 startUpdate_r;
    logic [OVERRUN_W-1:0] overrunCount_r;
    logic                 issue_s;
    logic                 drop_s;

    // Classify this cycle's strobe as an accepted start or an overrun.
    always_comb begin
        issue_s = enable && frameStart && (busy_r == '0);
        drop_s  = enable && frameStart && (busy_r != '0);
    end

    // Busy countdown keeps running even if the enable drops mid-update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_r         <= '0;
            startUpdate_r  <= 1'b0;
            overrunCount_r <= '0;
        end else begin
            startUpdate_r <= issue_s;
            if (issue_s) begin
                busy_r <= BUSY_LOAD;
            end else if (busy_r != '0) begin
                busy_r <= busy_r - BUSY_W'(1);
            end else begin
                busy_r <= busy_r;
            end
            if (drop_s && (overrunCount_r != '1)) begin
                overrunCount_r <= overrunCount_r + OVERRUN_W'(1);
            end else begin
                overrunCount_r <= overrunCount_r;
            end
        end
    end

    assign startUpdate  = startUpdate_r;
    assign overrunCount = overrunCount_r;

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: attract/play/lost/cleared/over flow, lives and
// level tracking, pause timing and ball re-serve, with the update scheduler.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int LIVES_INIT         = LIVES_INIT_DEFAULT,
    parameter int LOST_PAUSE_FRAMES  = LOST_PAUSE_DEFAULT,
    parameter int CLEAR_PAUSE_FRAMES = CLEAR_PAUSE_DEFAULT,
    parameter int UPDATE_CYCLES      = UPDATE_CYCLES_DEFAULT,
    parameter int OVERRUN_W          = OVERRUN_W_DEFAULT
) (
    input logic                  CLK,
    input logic                  RESET,
    game_flow_controller_if.slave bus
);

    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
    localparam logic [PAUSE_W-1:0] LOST_LOAD  = PAUSE_W'(LOST_PAUSE_FRAMES);
    localparam logic [PAUSE_W-1:0] CLEAR_LOAD = PAUSE_W'(CLEAR_PAUSE_FRAMES);

    gameState_t           state_r;
    logic [LIVES_W-1:0]   lives_r;
    logic [LEVEL_W-1:0]   level_r;
    logic [PAUSE_W-1:0]   pause_r;
    logic                 btnPrev_r;
    logic                 ballReset_r;

    logic                 startEdge_s;
    logic                 ballResetNext_s;
    logic                 schedEnable_s;
    logic                 startUpdate_s;
    logic [OVERRUN_W-1:0] overrunCount_s;

    // A re-serve suppresses the scheduler so both pulses never coincide.
    always_comb begin
        startEdge_s     = bus.BTN_START & ~btnPrev_r;
        ballResetNext_s = 1'b0;
        case (state_r)
            ST_ATTRACT:          ballResetNext_s = startEdge_s;
            ST_LOST, ST_CLEARED: ballResetNext_s = (pause_r == 8'd0);
            default:             ballResetNext_s = 1'b0;
        endcase
        schedEnable_s = (state_r == ST_PLAY) && !ballResetNext_s;
    end

    // Game flow FSM with lives, level and pause counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_ATTRACT;
            lives_r     <= 3'd0;
            level_r     <= 4'd0;
            pause_r     <= 8'd0;
            btnPrev_r   <= 1'b0;
            ballReset_r <= 1'b0;
        end else begin
            btnPrev_r   <= bus.BTN_START;
            ballReset_r <= ballResetNext_s;
            case (state_r)
                ST_ATTRACT: begin
                    if (startEdge_s) begin
                        state_r <= ST_PLAY;
                        lives_r <= LIVES_LOAD;
                        level_r <= 4'd0;
                    end
                end
                ST_PLAY: begin
                    // Clearing the level takes priority over a simultaneous loss.
                    if (bus.BRICKS_CLEARED) begin
                        state_r <= ST_CLEARED;
                        pause_r <= CLEAR_LOAD;
                    end else if (bus.BALL_LOST) begin
                        lives_r <= livesAfterLoss(lives_r);
                        if (lives_r <= 3'd1) begin
                            state_r <= ST_OVER;
                        end else begin
                            state_r <= ST_LOST;
                            pause_r <= LOST_LOAD;
                        end
                    end
                end
                ST_LOST, ST_CLEARED: begin
                    if (pause_r == 8'd0) begin
                        state_r <= ST_PLAY;
                        if (state_r == ST_CLEARED) begin
                            level_r <= levelSatInc(level_r);
                        end
                    end else if (bus.FRAME_START) begin
                        pause_r <= pause_r - 8'd1;
                    end
                end
                ST_OVER: begin
                    if (startEdge_s) begin
                        state_r <= ST_ATTRACT;
                    end
                end
                default: begin
                    state_r <= ST_ATTRACT;
                end
            endcase
        end
    end

    update_scheduler #(
        .UPDATE_CYCLES (UPDATE_CYCLES),
        .OVERRUN_W     (OVERRUN_W)
    ) u_scheduler (
        .CLK          (CLK),
        .RESET        (RESET),
        .enable       (schedEnable_s),
        .frameStart   (bus.FRAME_START),
        .startUpdate  (startUpdate_s),
        .overrunCount (overrunCount_s)
    );

    assign bus.START_UPDATE  = startUpdate_s;
    assign bus.BALL_RESET    = ballReset_r;
    assign bus.GAME_STATE    = state_r;
    assign bus.LIVES         = lives_r;
    assign bus.LEVEL         = level_r;
    assign bus.OVERRUN_COUNT = overrunCount_s;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: a cycle-level behavioural model is
// compared every cycle, plus hand-computed checkpoints along the game flow.
module tb_game_flow_controller;

    localparam int OW        = 8;
    localparam int LIVES0    = 3;
    localparam int LOSTP     = 60;
    localparam int CLEARP    = 120;
    localparam int UPD       = 3;
    localparam int OV_MAX    = 255;
    localparam int M_ATTRACT = 0;
    localparam int M_PLAY    = 1;
    localparam int M_LOST    = 2;
    localparam int M_CLEARED = 3;
    localparam int M_OVER    = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    game_flow_controller_if #(.OVERRUN_W(OW)) bus();

    game_flow_controller #(
        .LIVES_INIT         (LIVES0),
        .LOST_PAUSE_FRAMES  (LOSTP),
        .CLEAR_PAUSE_FRAMES (CLEARP),
        .UPDATE_CYCLES      (UPD),
        .OVERRUN_W          (OW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: game mode, counters, and the edge index of the last update issued.
    int  mMode = M_ATTRACT, mLives = 0, mLevel = 0, mOverrun = 0, mPause = 0;
    int  mEdge = 0, mLastIssue = -100, oldMode = 0;
    bit  mBtnPrev = 1'b0, mStart = 1'b0, mBallReset = 1'b0, press = 1'b0;

    initial begin
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                mMode = M_ATTRACT; mLives = 0; mLevel = 0; mOverrun = 0; mPause = 0;
                mEdge = 0; mLastIssue = -100; mBtnPrev = 1'b0; mStart = 1'b0; mBallReset = 1'b0;
            end else begin
                mEdge++;
                press    = bus.BTN_START && !mBtnPrev;
                mBtnPrev = bus.BTN_START;
                mStart = 1'b0; mBallReset = 1'b0;
                oldMode = mMode;
                // An update occupies UPD cycles plus its issue cycle before the next may start.
                if (oldMode == M_PLAY && bus.FRAME_START) begin
                    if (mEdge - mLastIssue >= UPD + 2) begin
                        mStart = 1'b1; mLastIssue = mEdge;
                    end else if (mOverrun < OV_MAX) begin
                        mOverrun++;
                    end
                end
                case (oldMode)
                    M_ATTRACT: if (press) begin
                        mMode = M_PLAY; mLives = LIVES0; mLevel = 0; mBallReset = 1'b1;
                    end
                    M_PLAY: if (bus.BRICKS_CLEARED) begin
                        mMode = M_CLEARED; mPause = CLEARP;
                    end else if (bus.BALL_LOST) begin
                        if (mLives <= 1) begin mLives = 0; mMode = M_OVER; end
                        else begin mLives--; mMode = M_LOST; mPause = LOSTP; end
                    end
                    M_LOST, M_CLEARED: if (mPause == 0) begin
                        mMode = M_PLAY; mBallReset = 1'b1;
                        if (oldMode == M_CLEARED && mLevel < 15) mLevel++;
                    end else if (bus.FRAME_START) begin
                        mPause--;
                    end
                    M_OVER: if (press) mMode = M_ATTRACT;
                    default: mMode = M_ATTRACT;
                endcase
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                chk("GAME_STATE",    int'(bus.GAME_STATE),    mMode);
                chk("LIVES",         int'(bus.LIVES),         mLives);
                chk("LEVEL",         int'(bus.LEVEL),         mLevel);
                chk("OVERRUN_COUNT", int'(bus.OVERRUN_COUNT), mOverrun);
                chk("START_UPDATE",  int'(bus.START_UPDATE),  int'(mStart));
                chk("BALL_RESET",    int'(bus.BALL_RESET),    int'(mBallReset));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame();
        @(negedge CLK) bus.FRAME_START = 1'b1;
        @(negedge CLK) bus.FRAME_START = 1'b0;
    endtask

    task automatic pulseEvents(input bit lost, input bit cleared);
        @(negedge CLK) begin bus.BALL_LOST = lost; bus.BRICKS_CLEARED = cleared; end
        @(negedge CLK) begin bus.BALL_LOST = 1'b0; bus.BRICKS_CLEARED = 1'b0; end
    endtask

    task automatic pausePhase(input int frames, input string tag);
        for (int i = 0; i < frames; i++) begin
            frame();
            chk({tag, " no update in pause"}, int'(bus.START_UPDATE), 0);
            idle(5);
        end
    endtask

    initial begin
        bus.FRAME_START = 1'b0; bus.BTN_START = 1'b0;
        bus.BALL_LOST = 1'b0; bus.BRICKS_CLEARED = 1'b0;
        RESET = 1'b1;
        idle(3);
        RESET = 1'b0;
        chk("reset GAME_STATE", int'(bus.GAME_STATE), 0);
        chk("reset LIVES", int'(bus.LIVES), 0);
        chk("reset OVERRUN_COUNT", int'(bus.OVERRUN_COUNT), 0);

        // Start press: PLAY one cycle later with a single re-serve pulse.
        @(negedge CLK) bus.BTN_START = 1'b1;
        @(negedge CLK);
        chk("start GAME_STATE", int'(bus.GAME_STATE), 1);
        chk("start LIVES", int'(bus.LIVES), 3);
        chk("start BALL_RESET", int'(bus.BALL_RESET), 1);
        bus.BTN_START = 1'b0;
        @(negedge CLK);
        chk("start BALL_RESET width", int'(bus.BALL_RESET), 0);

        // Frames 1000 cycles apart: each yields one update one cycle later.
        for (int i = 0; i < 3; i++) begin
            frame();
            chk("frame START_UPDATE", int'(bus.START_UPDATE), 1);
            idle(1);
            chk("frame START_UPDATE width", int'(bus.START_UPDATE), 0);
            idle(997);
        end

        // Strobe two cycles after an accepted one is dropped.
        frame();
        chk("overrun first START_UPDATE", int'(bus.START_UPDATE), 1);
        frame();
        chk("overrun OVERRUN_COUNT", int'(bus.OVERRUN_COUNT), 1);
        chk("overrun START_UPDATE", int'(bus.START_UPDATE), 0);

        // Ball loss with three lives, then the 60-frame pause.
        idle(10);
        pulseEvents(1'b1, 1'b0);
        chk("lost GAME_STATE", int'(bus.GAME_STATE), 2);
        chk("lost LIVES", int'(bus.LIVES), 2);
        pausePhase(LOSTP, "lost");
        chk("lost resume GAME_STATE", int'(bus.GAME_STATE), 1);

        // Simultaneous loss and clear: clear wins, no life lost.
        idle(10);
        pulseEvents(1'b1, 1'b1);
        chk("clear GAME_STATE", int'(bus.GAME_STATE), 3);
        chk("clear LIVES", int'(bus.LIVES), 2);
        pausePhase(CLEARP, "clear");
        chk("clear resume GAME_STATE", int'(bus.GAME_STATE), 1);
        chk("clear LEVEL", int'(bus.LEVEL), 1);

        idle(10);
        pulseEvents(1'b1, 1'b0);
        chk("lost2 LIVES", int'(bus.LIVES), 1);
        pausePhase(LOSTP, "lost2");

        // Last life lost with the button already held: OVER must not re-trigger.
        @(negedge CLK) bus.BTN_START = 1'b1;
        idle(2);
        pulseEvents(1'b1, 1'b0);
        chk("over GAME_STATE", int'(bus.GAME_STATE), 4);
        chk("over LIVES", int'(bus.LIVES), 0);
        idle(20);
        chk("over held GAME_STATE", int'(bus.GAME_STATE), 4);
        bus.BTN_START = 1'b0;
        idle(2);
        @(negedge CLK) bus.BTN_START = 1'b1;
        @(negedge CLK);
        chk("over press GAME_STATE", int'(bus.GAME_STATE), 0);
        bus.BTN_START = 1'b0;
        idle(2);
        @(negedge CLK) bus.BTN_START = 1'b1;
        @(negedge CLK);
        chk("new game GAME_STATE", int'(bus.GAME_STATE), 1);
        chk("new game LIVES", int'(bus.LIVES), 3);
        chk("new game LEVEL", int'(bus.LEVEL), 0);
        bus.BTN_START = 1'b0;

        // Strobe held every cycle long enough to saturate the overrun counter.
        idle(10);
        @(negedge CLK) bus.FRAME_START = 1'b1;
        idle(400);
        bus.FRAME_START = 1'b0;
        chk("overrun saturated", int'(bus.OVERRUN_COUNT), 255);

        // Reset asserted in the middle of a clear pause.
        idle(10);
        pulseEvents(1'b0, 1'b1);
        chk("clear2 GAME_STATE", int'(bus.GAME_STATE), 3);
        pausePhase(10, "clear2");
        #2 RESET = 1'b1;
        #1;
        chk("midreset GAME_STATE", int'(bus.GAME_STATE), 0);
        chk("midreset LIVES", int'(bus.LIVES), 0);
        chk("midreset LEVEL", int'(bus.LEVEL), 0);
        chk("midreset OVERRUN_COUNT", int'(bus.OVERRUN_COUNT), 0);
        chk("midreset START_UPDATE", int'(bus.START_UPDATE), 0);
        chk("midreset BALL_RESET", int'(bus.BALL_RESET), 0);
        @(negedge CLK) RESET = 1'b0;
        idle(3);
        chk("post reset GAME_STATE", int'(bus.GAME_STATE), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
